// File: rtl/special_walls_ram_if.sv
// Bus bundle for special_walls_ram: init control, packed read channels,
// masked read-modify-write port and the sticky range-error flag.
interface special_walls_ram_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_RD     = 2
);
  logic                           init_req;
  logic                           init_busy;
  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   rd_data;
  logic                           wr_en;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [1:0]                     wr_op;
  logic [DATA_WIDTH-1:0]          wr_mask;
  logic                           wr_ack;
  logic                           oor_err;

  modport master (
    output init_req, rd_addr, wr_en, wr_addr, wr_op, wr_mask,
    input  init_busy, rd_data, wr_ack, oor_err
  );

  modport slave (
    input  init_req, rd_addr, wr_en, wr_addr, wr_op, wr_mask,
    output init_busy, rd_data, wr_ack, oor_err
  );
endinterface

// File: rtl/special_walls_ram.sv
// Writable per-tile special-wall store: NUM_RD registered read channels, one
// masked RMW write port, and a sweep that refills every entry with INIT_VALUE.
module special_walls_ram #(
  parameter int DEPTH      = 167,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_RD     = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic Clk,
  input  logic Reset,
  special_walls_ram_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    busy;
  logic                    ready;
  logic                    wr_in_range;
  logic                    wr_accept;
  logic                    wr_oor;
  logic [DATA_WIDTH-1:0]   wr_old;
  logic [DATA_WIDTH-1:0]   wr_value;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_RD-1:0]       rd_oor;
  logic                    wr_ack_reg;
  logic                    oor_err_reg;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        if (bus.init_req) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        if (bus.init_req) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy  = (state_reg == ST_INIT);
  assign ready = (state_reg == ST_READY) && !Reset;

  // ---------------------------------------------------------- write path
  assign wr_in_range = in_range(bus.wr_addr);
  assign wr_accept   = ready && bus.wr_en && wr_in_range;
  assign wr_oor      = ready && bus.wr_en && !wr_in_range;
  assign wr_old      = mem[bus.wr_addr];

  always_comb begin
    wr_value = wr_old;
    case (bus.wr_op)
      2'b00: wr_value = bus.wr_mask;
      2'b01: wr_value = wr_old & ~bus.wr_mask;
      2'b10: wr_value = wr_old | bus.wr_mask;
      2'b11: wr_value = wr_old ^ bus.wr_mask;
      default: wr_value = wr_old;
    endcase
  end

  // The sweep and the user port share the single array write port; they are
  // mutually exclusive because user writes only land in READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = wr_value;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg;
      mem_wdata = INIT_VALUE;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ----------------------------------------------------------- read path
  // Reads sample the array before this edge's write lands: read-before-write.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data_reg;

      assign addr       = bus.rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign rd_oor[gi] = ready && !in_range(addr);

      always_ff @(posedge Clk) begin
        if (Reset) begin
          data_reg <= '0;
        end else if (busy) begin
          data_reg <= INIT_VALUE;
        end else if (in_range(addr)) begin
          data_reg <= mem[addr];
        end else begin
          data_reg <= '0;
        end
      end

      assign bus.rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = data_reg;
    end
  endgenerate

  // --------------------------------------------------------- status flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ack_reg  <= 1'b0;
      oor_err_reg <= 1'b0;
    end else begin
      wr_ack_reg <= wr_accept;
      if (bus.init_req) begin
        oor_err_reg <= 1'b0;
      end else if (wr_oor || (|rd_oor)) begin
        oor_err_reg <= 1'b1;
      end
    end
  end

  assign bus.init_busy = busy;
  assign bus.wr_ack    = wr_ack_reg;
  assign bus.oor_err   = oor_err_reg;

endmodule

// File: tb/tb_special_walls_ram.sv
// Directed and randomized checks of special_walls_ram against a cycle-level
// behavioural model built from the tile-store rules (array + countdown).
module tb_special_walls_ram;

  localparam int DEPTH = 167;
  localparam int AW    = 8;
  localparam int DW    = 4;
  localparam int NR    = 2;
  localparam logic [DW-1:0] INITV = 4'hF;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  special_walls_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

  special_walls_ram #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .INIT_VALUE(INITV)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  logic              init_req_v;
  logic [NR*AW-1:0]  rd_addr_v;
  logic              wr_en_v;
  logic [AW-1:0]     wr_addr_v;
  logic [1:0]        wr_op_v;
  logic [DW-1:0]     wr_mask_v;

  assign bus.init_req = init_req_v;
  assign bus.rd_addr  = rd_addr_v;
  assign bus.wr_en    = wr_en_v;
  assign bus.wr_addr  = wr_addr_v;
  assign bus.wr_op    = wr_op_v;
  assign bus.wr_mask  = wr_mask_v;

  // Reference model state
  logic [DW-1:0] mdl [DEPTH];
  int            busy_left;
  logic          m_oor;

  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rd_ch(input int i);
    return bus.rd_data[i*DW +: DW];
  endfunction

  task automatic set_rd(input int i, input int a);
    rd_addr_v[i*AW +: AW] = AW'(a);
  endtask

  task automatic idle();
    init_req_v = 1'b0;
    wr_en_v    = 1'b0;
  endtask

  // One clock: predict from the model, advance the model, then compare.
  task automatic cycle();
    logic [DW-1:0] exp_rd [NR];
    logic          exp_ack, exp_oor, exp_busy, any_oor;
    logic [DW-1:0] m, nv;
    int            a;
    exp_ack = 1'b0;
    any_oor = 1'b0;
    if (Reset) begin
      for (int i = 0; i < NR; i++) exp_rd[i] = '0;
      exp_oor   = 1'b0;
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      for (int i = 0; i < NR; i++) exp_rd[i] = INITV;
      exp_oor = init_req_v ? 1'b0 : m_oor;
      if (init_req_v) begin
        busy_left = DEPTH;
      end else begin
        busy_left--;
        if (busy_left == 0)
          for (int k = 0; k < DEPTH; k++) mdl[k] = INITV;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        a = int'(rd_addr_v[i*AW +: AW]);
        if (a < DEPTH) exp_rd[i] = mdl[a];
        else begin
          exp_rd[i] = '0;
          any_oor   = 1'b1;
        end
      end
      if (wr_en_v) begin
        if (int'(wr_addr_v) < DEPTH) begin
          exp_ack = 1'b1;
          m = mdl[wr_addr_v];
          case (wr_op_v)
            2'b00:   nv = wr_mask_v;
            2'b01:   nv = m & ~wr_mask_v;
            2'b10:   nv = m | wr_mask_v;
            default: nv = m ^ wr_mask_v;
          endcase
          mdl[wr_addr_v] = nv;
        end else begin
          any_oor = 1'b1;
        end
      end
      exp_oor = init_req_v ? 1'b0 : (m_oor | any_oor);
      if (init_req_v) busy_left = DEPTH;
    end
    m_oor    = exp_oor;
    exp_busy = (busy_left > 0);

    @(posedge Clk);
    #1;
    for (int i = 0; i < NR; i++) chk($sformatf("rd_data%0d", i), 32'(rd_ch(i)), 32'(exp_rd[i]));
    chk("wr_ack", 32'(bus.wr_ack), 32'(exp_ack));
    chk("oor_err", 32'(bus.oor_err), 32'(exp_oor));
    chk("init_busy", 32'(bus.init_busy), 32'(exp_busy));
  endtask

  task automatic wait_sweep(input string tag, input int expect_len);
    int n = 0;
    while (bus.init_busy === 1'b1 && n < 1000) begin
      cycle();
      n++;
    end
    chk(tag, 32'(n), 32'(expect_len));
  endtask

  task automatic do_write(input int a, input logic [1:0] op, input logic [DW-1:0] mask);
    wr_en_v   = 1'b1;
    wr_addr_v = AW'(a);
    wr_op_v   = op;
    wr_mask_v = mask;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_oor       = 1'b0;
    busy_left   = DEPTH;
    for (int k = 0; k < DEPTH; k++) mdl[k] = INITV;
    Reset = 1'b1;
    idle();
    rd_addr_v = '0;
    wr_addr_v = '0;
    wr_op_v   = 2'b00;
    wr_mask_v = '0;

    // Reset for two cycles, then the full sweep
    cycle();
    cycle();
    Reset = 1'b0;
    wait_sweep("busy_len_reset", DEPTH);

    // Post-sweep reads of 0, 83, 166
    set_rd(0, 0);  set_rd(1, 83);  cycle();
    chk("init_rd0", 32'(rd_ch(0)), 32'hF);
    chk("init_rd83", 32'(rd_ch(1)), 32'hF);
    set_rd(0, 166); cycle();
    chk("init_rd166", 32'(rd_ch(0)), 32'hF);

    // RMW sequence on address 10
    set_rd(0, 10); set_rd(1, 11);
    do_write(10, 2'b01, 4'b0101); cycle(); chk("ack_op01", 32'(bus.wr_ack), 32'd1);
    idle(); cycle(); chk("rmw_op01", 32'(rd_ch(0)), 32'hA);
    do_write(10, 2'b11, 4'b0101); cycle(); chk("ack_op11", 32'(bus.wr_ack), 32'd1);
    idle(); cycle(); chk("rmw_op11", 32'(rd_ch(0)), 32'hF);
    do_write(10, 2'b00, 4'b0011); cycle();
    idle(); cycle(); chk("rmw_op00", 32'(rd_ch(0)), 32'h3);
    do_write(10, 2'b10, 4'b1000); cycle();
    idle(); cycle(); chk("rmw_op10", 32'(rd_ch(0)), 32'hB);

    // Dual-channel read-before-write collision
    set_rd(0, 20); set_rd(1, 21);
    do_write(20, 2'b00, 4'b0000); cycle();
    chk("coll_ch0", 32'(rd_ch(0)), 32'hF);
    chk("coll_ch1", 32'(rd_ch(1)), 32'hF);
    idle(); cycle();
    chk("coll_after", 32'(rd_ch(0)), 32'h0);

    // Randomized traffic focused on a few addresses to compound RMWs
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NR; i++)
        set_rd(i, ($urandom_range(0, 31) == 0) ? int'($urandom_range(DEPTH, 255))
                                               : int'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 1)
        do_write(($urandom_range(0, 40) == 0) ? int'($urandom_range(DEPTH, 255))
                                              : int'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), DW'($urandom_range(0, 15)));
      else
        wr_en_v = 1'b0;
      cycle();
    end
    idle();

    // Out-of-range read, write, and clear by init_req
    set_rd(0, 200); set_rd(1, 5); cycle();
    chk("oor_rd_data", 32'(rd_ch(0)), 32'h0);
    chk("oor_flag", 32'(bus.oor_err), 32'd1);
    set_rd(0, 30);
    do_write(170, 2'b00, 4'b0000); cycle();
    chk("oor_wr_noack", 32'(bus.wr_ack), 32'd0);
    idle(); cycle();
    for (int k = 0; k < DEPTH; k += 2) begin
      set_rd(0, k); set_rd(1, k + 1 < DEPTH ? k + 1 : 0); cycle();
    end
    do_write(25, 2'b00, 4'b0110); cycle();
    idle(); init_req_v = 1'b1; set_rd(0, 25); set_rd(1, 20); cycle();
    chk("oor_cleared", 32'(bus.oor_err), 32'd0);
    init_req_v = 1'b0;

    // Sweep restarted at cnt=50, with a dropped write during the sweep
    for (int k = 0; k < 50; k++) begin
      if (k == 10) do_write(20, 2'b00, 4'b0000);
      else wr_en_v = 1'b0;
      cycle();
    end
    init_req_v = 1'b1; cycle();
    init_req_v = 1'b0;
    wait_sweep("busy_len_restart", DEPTH);
    set_rd(0, 20); set_rd(1, 25); cycle();
    chk("swept_20", 32'(rd_ch(0)), 32'hF);
    chk("swept_25", 32'(rd_ch(1)), 32'hF);

    // Reset mid-sweep at cnt=100
    do_write(40, 2'b01, 4'b1111); cycle();
    idle(); init_req_v = 1'b1; cycle();
    init_req_v = 1'b0;
    for (int k = 0; k < 100; k++) cycle();
    Reset = 1'b1; cycle();
    chk("rst_mid_rd", 32'(rd_ch(0)), 32'h0);
    chk("rst_mid_busy", 32'(bus.init_busy), 32'd1);
    Reset = 1'b0;
    wait_sweep("busy_len_rst_mid", DEPTH);
    set_rd(0, 40); set_rd(1, 166); cycle();
    chk("post_rst_40", 32'(rd_ch(0)), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
